// File: rtl/line_memory_ctrl.sv
// Line-wide backing memory and request engine behind the split I/D cache.
// Ports: clk, reset (async, high); i_/d_ addressM, readM, writeM, dataM
// (inout line bus), readyM (completion pulse); protocol_err (sticky).
// Optional LINE_MEM_STATS_EN adds rd_cnt, wr_cnt, conflict_cnt outputs.
module line_memory_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 64,
  parameter int DEPTH_LINES = 16384,
  parameter int LATENCY     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addressM,
  input  logic                  i_readM,
  input  logic                  i_writeM,
  inout  wire  [LINE_WIDTH-1:0] i_dataM,
  output logic                  i_readyM,
  input  logic [ADDR_WIDTH-1:0] d_addressM,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  inout  wire  [LINE_WIDTH-1:0] d_dataM,
  output logic                  d_readyM,
  output logic                  protocol_err
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int IW = $clog2(DEPTH_LINES);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            i_req_q, d_req_q;
  logic            i_pend_q, i_pend_d;
  logic            d_pend_q, d_pend_d;
  logic            i_wr_q, i_wr_d;
  logic            d_wr_q, d_wr_d;
  logic [IW-1:0]   i_idx_q, i_idx_d;
  logic [IW-1:0]   d_idx_q, d_idx_d;
  logic            err_q, err_d;

  logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES];

  // Low line-index bits only: upper address bits wrap modulo depth.
  function automatic logic [IW-1:0] idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return IW'(a >> 2);
  endfunction

  logic i_new, d_new, i_ok, d_ok;
  logic i_rdy, d_rdy, done;
  logic on_i, on_d, act_wr, wr_en;
  logic [IW-1:0] act_idx;

  always_comb begin
    on_i  = (state_q == BUSY_I);
    on_d  = (state_q == BUSY_D);
    done  = (on_i | on_d) & (cnt_q == 4'd0);
    i_new = (i_readM | i_writeM) & ~i_req_q;
    d_new = (d_readM | d_writeM) & ~d_req_q;
    // A port may hold at most one transaction, queued or in service.
    i_ok  = i_new & ~(i_readM & i_writeM)
          & ~i_pend_q & ~on_i;
    d_ok  = d_new & ~(d_readM & d_writeM)
          & ~d_pend_q & ~on_d;
    i_rdy = i_pend_q | i_ok;
    d_rdy = d_pend_q | d_ok;
    act_idx = on_d ? d_idx_q : i_idx_q;
    act_wr  = on_d ? d_wr_q : i_wr_q;
    wr_en   = done & act_wr & ~reset;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_pend_d = i_pend_q;
    d_pend_d = d_pend_q;
    i_wr_d   = i_wr_q;
    d_wr_d   = d_wr_q;
    i_idx_d  = i_idx_q;
    d_idx_d  = d_idx_q;
    err_d    = err_q | (i_new & ~i_ok)
             | (d_new & ~d_ok);
    if (i_ok) begin
      i_pend_d = 1'b1;
      i_idx_d  = idx_of(i_addressM);
      i_wr_d   = i_writeM;
    end
    if (d_ok) begin
      d_pend_d = 1'b1;
      d_idx_d  = idx_of(d_addressM);
      d_wr_d   = d_writeM;
    end
    unique case (state_q)
      IDLE: begin
        if (d_rdy) begin
          state_d  = BUSY_D;
          d_pend_d = 1'b0;
          cnt_d    = CNT_INIT;
        end else if (i_rdy) begin
          state_d  = BUSY_I;
          i_pend_d = 1'b0;
          cnt_d    = CNT_INIT;
        end
      end
      BUSY_I: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (d_rdy) begin
          state_d  = BUSY_D;
          d_pend_d = 1'b0;
          cnt_d    = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_D: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (i_rdy) begin
          state_d  = BUSY_I;
          i_pend_d = 1'b0;
          cnt_d    = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_req_q  <= 1'b0;
      d_req_q  <= 1'b0;
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
      i_wr_q   <= 1'b0;
      d_wr_q   <= 1'b0;
      i_idx_q  <= '0;
      d_idx_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_req_q  <= i_readM | i_writeM;
      d_req_q  <= d_readM | d_writeM;
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      i_wr_q   <= i_wr_d;
      d_wr_q   <= d_wr_d;
      i_idx_q  <= i_idx_d;
      d_idx_q  <= d_idx_d;
      err_q    <= err_d;
    end
  end

  // Array holds its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[act_idx] <= on_d ? d_dataM : i_dataM;
    end
  end

  assign i_readyM     = done & on_i;
  assign d_readyM     = done & on_d;
  assign protocol_err = err_q;

  assign i_dataM = (i_readyM & ~i_wr_q)
                 ? mem_q[act_idx] : 'z;
  assign d_dataM = (d_readyM & ~d_wr_q)
                 ? mem_q[act_idx] : 'z;

`ifdef LINE_MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] cf_cnt_q, cf_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    cf_cnt_d = cf_cnt_q;
    if (done & ~act_wr) rd_cnt_d = rd_cnt_q + 16'd1;
    if (done & act_wr)  wr_cnt_d = wr_cnt_q + 16'd1;
    if ((on_i & d_pend_q) | (on_d & i_pend_q))
      cf_cnt_d = cf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;
  assign conflict_cnt = cf_cnt_q;
`endif

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl against a transaction-level model.
// Also checks a LATENCY=1 instance for its short-latency timing.
module tb_line_memory_ctrl;
  localparam int LAT  = 3;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] i_addressM, d_addressM;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  wire  [63:0] i_dataM, d_dataM;
  wire         i_readyM, d_readyM, protocol_err;

  logic [15:0] a1_addr;
  logic        a1_rd;
  wire  [63:0] b1_i, b1_d;
  wire         r1_i, r1_d, e1;

`ifdef LINE_MEM_STATS_EN
  wire [15:0] rd_cnt, wr_cnt, conflict_cnt;
  wire [15:0] rd1, wr1, cf1;
`endif

  line_memory_ctrl #(.LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .i_addressM(i_addressM), .i_readM(i_readM),
    .i_writeM(i_writeM), .i_dataM(i_dataM),
    .i_readyM(i_readyM),
    .d_addressM(d_addressM), .d_readM(d_readM),
    .d_writeM(d_writeM), .d_dataM(d_dataM),
    .d_readyM(d_readyM),
    .protocol_err(protocol_err)
`ifdef LINE_MEM_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  line_memory_ctrl #(.LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .i_addressM(16'h0), .i_readM(1'b0),
    .i_writeM(1'b0), .i_dataM(b1_i),
    .i_readyM(r1_i),
    .d_addressM(a1_addr), .d_readM(a1_rd),
    .d_writeM(1'b0), .d_dataM(b1_d),
    .d_readyM(r1_d),
    .protocol_err(e1)
`ifdef LINE_MEM_STATS_EN
    , .rd_cnt(rd1), .wr_cnt(wr1),
    .conflict_cnt(cf1)
`endif
  );

  int cyc = 0;
  int dcyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 dcyc = cyc;
  end

  // Model: per-cycle expectations derived from transaction order.
  bit          e_irdy [MAXC];
  bit          e_drdy [MAXC];
  bit          e_ird  [MAXC];
  bit          e_drd  [MAXC];
  logic [63:0] e_ival [MAXC];
  logic [63:0] e_dval [MAXC];
  bit          dr_i   [MAXC];
  bit          dr_d   [MAXC];
  logic [63:0] dv_i   [MAXC];
  logic [63:0] dv_d   [MAXC];
  logic [63:0] mdl [int];
  int last_comp = -100;
  int err_from  = 1 << 30;

  assign i_dataM = dr_i[dcyc] ? dv_i[dcyc] : 'z;
  assign d_dataM = dr_d[dcyc] ? dv_d[dcyc] : 'z;

  // One engine: a transaction ends LAT cycles after the later of
  // its request cycle and the previous completion.
  task automatic issue(input bit dp, input bit wr,
                       input logic [15:0] addr,
                       input logic [63:0] data,
                       input int c0, output int comp);
    int line;
    line = (int'(addr) >> 2) % 16384;
    comp = ((c0 > last_comp) ? c0 : last_comp) + LAT;
    last_comp = comp;
    if (dp) e_drdy[comp] = 1'b1;
    else    e_irdy[comp] = 1'b1;
    if (wr) begin
      for (int c = c0; c <= comp; c++) begin
        if (dp) begin dr_d[c] = 1'b1; dv_d[c] = data; end
        else    begin dr_i[c] = 1'b1; dv_i[c] = data; end
      end
      mdl[line] = data;
    end else if (dp) begin
      e_drd[comp] = 1'b1;
      e_dval[comp] = mdl[line];
    end else begin
      e_ird[comp] = 1'b1;
      e_ival[comp] = mdl[line];
    end
  endtask

  task automatic abort_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      e_irdy[k] = 1'b0; e_drdy[k] = 1'b0;
      e_ird[k]  = 1'b0; e_drd[k]  = 1'b0;
      dr_i[k]   = 1'b0; dr_d[k]   = 1'b0;
    end
    last_comp = -100;
    err_from  = 1 << 30;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm,
                          input logic [63:0] act);
    total++;
    if (!(act === 64'h0 || act === {64{1'bz}})) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=Z",
               nm, cyc, act);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      chk("d_ready", {63'b0, d_readyM}, {63'b0, e_drdy[cyc]});
      chk("i_ready", {63'b0, i_readyM}, {63'b0, e_irdy[cyc]});
      chk("err", {63'b0, protocol_err},
          {63'b0, (cyc >= err_from)});
      if (e_drd[cyc])     chk("d_data", d_dataM, e_dval[cyc]);
      else if (!dr_d[cyc]) chk_idle("d_bus", d_dataM);
      if (e_ird[cyc])     chk("i_data", i_dataM, e_ival[cyc]);
      else if (!dr_i[cyc]) chk_idle("i_bus", i_dataM);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dxact(input bit wr, input logic [15:0] a,
                       input logic [63:0] v, output int comp);
    d_addressM = a;
    if (wr) d_writeM = 1'b1;
    else    d_readM  = 1'b1;
    issue(1'b1, wr, a, v, cyc, comp);
    step(1);
    d_writeM = 1'b0;
    d_readM  = 1'b0;
  endtask

  int c0, ci, cd;
  logic [63:0] old;

  initial begin
    i_addressM = '0; d_addressM = '0;
    i_readM = 0; i_writeM = 0;
    d_readM = 0; d_writeM = 0;
    a1_addr = '0; a1_rd = 0;
    step(3);
    reset = 1'b0;
    step(1);

    // Preload lines 5 and 12 through the write port.
    dxact(1'b1, 16'h0014, 64'h0004_0003_0002_0001, cd);
    step(cd - cyc + 1);
    dxact(1'b1, 16'h0030, 64'h1212_3434_5656_7878, cd);
    step(cd - cyc + 1);

    // Single D read with fixed latency.
    c0 = cyc;
    dxact(1'b0, 16'h0014, 64'h0, cd);
    chk("lat_read", 64'(cd - c0), 64'd3);
    step(cd - cyc);
    @(negedge clk);
    chk("t1_data", d_dataM, 64'h0004_0003_0002_0001);
    chk("t1_rdy", {63'b0, d_readyM}, 64'd1);
    step(1);

    // Write-back then read back.
    dxact(1'b1, 16'h0020, 64'hDEAD_BEEF_CAFE_F00D, cd);
    step(cd - cyc + 1);
    dxact(1'b0, 16'h0020, 64'h0, cd);
    step(cd - cyc);
    @(negedge clk);
    chk("t2_data", d_dataM, 64'hDEAD_BEEF_CAFE_F00D);
    step(1);

    // Simultaneous I and D reads: D first, I queued.
    c0 = cyc;
    i_addressM = 16'h0014; i_readM = 1'b1;
    d_addressM = 16'h0020; d_readM = 1'b1;
    issue(1'b1, 1'b0, 16'h0020, 64'h0, c0, cd);
    issue(1'b0, 1'b0, 16'h0014, 64'h0, c0, ci);
    chk("arb_d", 64'(cd - c0), 64'd3);
    chk("arb_i", 64'(ci - c0), 64'd6);
    step(1);
    i_readM = 1'b0; d_readM = 1'b0;
    step(ci - cyc);
    @(negedge clk);
    chk("t3_i_data", i_dataM, 64'h0004_0003_0002_0001);
    step(1);
`ifdef LINE_MEM_STATS_EN
    chk("conflict", {48'b0, conflict_cnt}, 64'd3);
    chk("rd_cnt", {48'b0, rd_cnt}, 64'd4);
    chk("wr_cnt", {48'b0, wr_cnt}, 64'd3);
`endif

    // Reset in the third cycle of a write aborts it.
    old = mdl[12];
    c0 = cyc;
    dxact(1'b1, 16'h0030, 64'h0BAD_0BAD_0BAD_0BAD, cd);
    step(1);
    reset = 1'b1;
    abort_from(cyc);
    mdl[12] = old;
    @(negedge clk);
    chk("rst_err", {63'b0, protocol_err}, 64'd0);
    step(1);
    reset = 1'b0;
    step(1);
    dxact(1'b0, 16'h0030, 64'h0, cd);
    step(cd - cyc);
    @(negedge clk);
    chk("t4_keep", d_dataM, 64'h1212_3434_5656_7878);
    step(1);

    // Second I edge while the first I read is in service.
    c0 = cyc;
    i_addressM = 16'h0014; i_readM = 1'b1;
    issue(1'b0, 1'b0, 16'h0014, 64'h0, c0, ci);
    step(1);
    i_readM = 1'b0;
    step(1);
    i_readM = 1'b1;
    err_from = cyc + 1;
    step(1);
    i_readM = 1'b0;
    step(8);
    @(negedge clk);
    chk("t5_sticky", {63'b0, protocol_err}, 64'd1);
    step(1);

    // Reset clears the flag; read+write together sets it again.
    reset = 1'b1;
    abort_from(cyc);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_clr", {63'b0, protocol_err}, 64'd0);
    step(1);
    d_readM = 1'b1; d_writeM = 1'b1;
    err_from = cyc + 1;
    step(1);
    d_readM = 1'b0; d_writeM = 1'b0;
    step(5);
    @(negedge clk);
    chk("t6_both", {63'b0, protocol_err}, 64'd1);
    step(1);

    // LATENCY=1 instance: C0 request, C1 ready, C2 request, C3 ready.
    a1_rd = 1'b1;
    @(negedge clk);
    chk("l1_c0", {63'b0, r1_d}, 64'd0);
    step(1);
    a1_rd = 1'b0;
    @(negedge clk);
    chk("l1_c1", {63'b0, r1_d}, 64'd1);
    step(1);
    a1_rd = 1'b1;
    @(negedge clk);
    chk("l1_c2", {63'b0, r1_d}, 64'd0);
    step(1);
    a1_rd = 1'b0;
    @(negedge clk);
    chk("l1_c3", {63'b0, r1_d}, 64'd1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_memory_ctrl.md
Name: line_memory_ctrl

Overview:
- Unified backing memory plus request engine directly downstream of the split I/D cache.
- Serves whole 64-bit lines (4 x 16-bit words) to the I-side and D-side miss/write-back ports, with fixed latency.
- Arbitrates one transaction at a time, with one-deep pending capture per port.
- Returns read lines on the bidirectional line buses and pulses a per-port ready when each transaction ends.

Parameters:
- ADDR_WIDTH, 16, word address width; line index = address[ADDR_WIDTH-1:2], address[1:0] ignored.
- LINE_WIDTH, 64, line size in bits (4 words).
- DEPTH_LINES, 16384, number of lines in the backing array.
- LATENCY, 3, cycles from request-sample edge to the data/ready cycle; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_addressM  input  ADDR_WIDTH  I-side line address.
- i_readM  input  1  I-side read request (level).
- i_writeM  input  1  I-side write request (level).
- i_dataM  inout  LINE_WIDTH  I-side line bus; driven only in the I read-return cycle, else Z.
- i_readyM  output  1  one-cycle pulse at I transaction completion.
- d_addressM  input  ADDR_WIDTH  D-side line address.
- d_readM  input  1  D-side read request.
- d_writeM  input  1  D-side write-back request.
- d_dataM  inout  LINE_WIDTH  D-side line bus; driven only in the D read-return cycle, else Z.
- d_readyM  output  1  one-cycle pulse at D transaction completion.
- protocol_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, active-high):
  - i_readyM=0, d_readyM=0, protocol_err=0; both dataM buses Z.
  - Engine to IDLE; pending flags, edge registers and counter cleared.
  - Array contents are NOT cleared.
- Request detection, per port:
  - req = readM|writeM, registered as req_q; a new request is req & ~req_q.
  - Address and op type are captured on that edge.
  - readM & writeM both high on a new edge: request dropped, protocol_err set.
  - New edge while the same port already has a pending or active transaction: dropped, protocol_err set.
- Engine states: IDLE, BUSY_I, BUSY_D.
  - IDLE: a captured request (new or pending) starts at the next edge. D wins over I when both are ready; the loser stays pending.
  - BUSY_x: counter loaded with LATENCY-1 at entry, decremented each cycle. The cycle with counter==0 is the completion cycle.
  - Completion cycle, read: x_dataM driven with array[line]; x_readyM=1.
  - Completion cycle, write: x_dataM sampled at the end of the cycle and written to array[line]; x_readyM=1.
  - After completion: go to BUSY of the other port if it is pending, else IDLE.
- Timing: request seen high during cycle C0 with the engine idle → data/ready in cycle C0+LATENCY. With the default of 3, data is valid in the fourth cycle counted from the request cycle.
- A queued request completes exactly LATENCY cycles after the previous completion cycle.
- Bus drive is combinational from the state: a port's bus is never driven outside its own read completion cycle, and never during writes.
- Address bits above the line index map modulo DEPTH_LINES.
- Reset mid-transaction: aborted; no array write is committed; ready is not pulsed; buses go to Z immediately.
- The requester may drop readM/writeM any time after the request edge; this does not cancel the transaction.

Optional Feature:
- Macro: LINE_MEM_STATS_EN.
- Defined: three extra outputs, rd_cnt[15:0], wr_cnt[15:0], conflict_cnt[15:0], all reset to 0.
  - rd_cnt increments on each read completion.
  - wr_cnt increments on each write completion.
  - conflict_cnt increments each cycle a request is pending while the engine serves the other port.
  - All three wrap at 16'hFFFF → 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Preload array[5]=64'h0004_0003_0002_0001; pulse d_readM with d_addressM=16'h0014 in C0 → d_dataM=64'h0004_0003_0002_0001 and d_readyM=1 in C3 only; Z elsewhere; i_readyM stays 0.
- d_writeM with d_addressM=16'h0020, d_dataM=64'hDEAD_BEEF_CAFE_F00D driven in C3 → d_readyM pulse in C3; a following read of 16'h0020 returns 64'hDEAD_BEEF_CAFE_F00D.
- i_readM and d_readM rise in the same cycle C0 → d_readyM in C3, i_readyM in C6; with stats enabled, conflict_cnt=3.
- Assert reset in C2 of a d_writeM to 16'h0030 → no ready pulse; array[12] unchanged; buses Z; protocol_err=0.
- Second i_readM rising edge while the first I read is still busy → dropped; protocol_err=1 and it remains 1 until reset.
- LATENCY=1 build: d_readM in C0 → d_readyM in C1; back-to-back D reads (request in C2) → d_readyM in C3.
